// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer sizing, level legality and
// count-to-status decode.
package fifo_pkg;

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit levels_legal(input int unsigned depth,
                                      input int unsigned af_level,
                                      input int unsigned ae_level);
    return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

  function automatic fifo_flags_t flags_decode(input int unsigned count,
                                               input int unsigned depth,
                                               input int unsigned af_level,
                                               input int unsigned ae_level);
    fifo_flags_t f;
    f.wfull        = (count == depth);
    f.rempty       = (count == 0);
    f.almost_full  = (count >= af_level);
    f.almost_empty = (count <= ae_level);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// The array itself is never reset; only the read register is.
module fifo_mem_dp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointer/count control, status decode and sticky error
// flags around a dual-port storage array with one-cycle registered read.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  import fifo_pkg::*;

  localparam int unsigned PTR_W    = ptr_width(ADDR_WIDTH);
  localparam int unsigned FIFO_DEP = 1 << ADDR_WIDTH;

  if (!levels_legal(FIFO_DEP, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("sync_fifo_ctrl: AF_LEVEL/AE_LEVEL out of range for depth");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             r_valid_q, r_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  fifo_flags_t      flags;

  // Status is a pure decode of the registered count.
  assign flags = flags_decode(32'(count_q), FIFO_DEP, AF_LEVEL, AE_LEVEL);

  always_comb begin
    wr_acc      = winc & ~flags.wfull;
    rd_acc      = rinc & ~flags.rempty;
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_acc);
    count_d     = count_q;
    r_valid_d   = rd_acc;
    overflow_d  = (winc & flags.wfull)  | (overflow_q  & ~clr_err);
    underflow_d = (rinc & flags.rempty) | (underflow_q & ~clr_err);
    if (wr_acc && !rd_acc) begin
      count_d = count_q + PTR_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write and read never target the same live entry, so no bypass is needed.
  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (wr_acc & ~RST),
    .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(w_data),
    .re_i   (rd_acc & ~RST),
    .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(r_data)
  );

  assign r_valid      = r_valid_q;
  assign wfull        = flags.wfull;
  assign rempty       = flags.rempty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign fill_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
